// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU, load and jal-link writebacks, merging sub-word loads via read-modify-write
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LINK_REG = 31,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        ld_size,
  output logic              ld_ready,
  input  logic              link_valid,
  input  logic [DATA_W-1:0] link_pc,
  output logic              link_ready,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  typedef enum logic [1:0] {IDLE, WRITE, RD, MERGE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] waddr_q, acc_addr;
  logic [DATA_W-1:0] wdata_q, acc_data, mask;
  logic we_q, rmw_q, half_q;
  logic open, starve, g_alu, g_ld, g_link, sub;
  // Grant selection (link > load > alu unless the ALU has starved) and next state
  always_comb begin
    open = reset_n && (state == IDLE || state == WRITE);
    starve = alu_valid && cnt == CW'(STARVE_LIM);
    g_alu = open && alu_valid && (starve || (!link_valid && !ld_valid));
    g_link = open && link_valid && !starve;
    g_ld = open && ld_valid && !link_valid && !starve;
    sub = g_ld && (ld_size == 2'b01 || ld_size == 2'b10) && ld_addr != '0;
    acc_addr = g_link ? ADDR_W'(LINK_REG) : g_ld ? ld_addr : alu_addr;
    acc_data = g_link ? link_pc + DATA_W'(4) : g_ld ? ld_data : alu_data;
    mask = half_q ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF);
    state_n = state == RD ? MERGE :
              state == MERGE ? WRITE :
              sub ? RD :
              (g_alu || g_ld || g_link) ? WRITE : IDLE;
  end
  // State register; reset abandons any RMW in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end
  // Latch the accepted write, splice read data under the sub-word, count ALU waiting cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rmw_q <= 1'b0;
      half_q <= 1'b0;
    end else begin
      cnt <= (!alu_valid || g_alu) ? '0 : starve ? cnt : cnt + 1'b1;
      if (g_alu || g_ld || g_link) begin
        waddr_q <= acc_addr;
        wdata_q <= acc_data;
        we_q <= acc_addr != '0;
        rmw_q <= sub;
        half_q <= ld_size == 2'b01;
      end else if (state == MERGE)
        wdata_q <= (rf_rd_data & ~mask) | (wdata_q & mask);
    end
  end
  assign alu_ready = g_alu;
  assign ld_ready = g_ld;
  assign link_ready = g_link;
  assign rf_we = state == WRITE && we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign rf_rd_en = state == RD;
  assign rf_rd_addr = waddr_q;
  assign busy = state == RD || state == MERGE || (state == WRITE && rmw_q);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks of the writeback arbiter against a cycle-schedule model
module tb_regfile_wb_arbiter;
  localparam int STARVE = 4;
  logic clk = 1'b0;
  logic reset_n;
  logic alu_valid, ld_valid, link_valid;
  logic [4:0] alu_addr, ld_addr, rf_rd_addr, rf_waddr;
  logic [31:0] alu_data, ld_data, link_pc, rf_rd_data, rf_wdata;
  logic [1:0] ld_size;
  logic alu_ready, ld_ready, link_ready, rf_rd_en, rf_we, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int closed_until = 0;
  int alu_wait = 0;
  logic [31:0] mem [32];
  bit e_we [8];
  bit e_rd [8];
  bit e_busy [8];
  bit e_mrg [8];
  bit e_half [8];
  logic [4:0] e_addr [8];
  logic [4:0] e_raddr [8];
  logic [31:0] e_data [8];

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_size(ld_size), .ld_ready(ld_ready),
    .link_valid(link_valid), .link_pc(link_pc), .link_ready(link_ready),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;
  // Register-file read port: data appears the cycle after the address
  always @(posedge clk) rf_rd_data <= mem[rf_rd_addr];

  task automatic sched(input int n, input logic [4:0] a, input logic [31:0] d);
    e_we[n] = a != 5'd0;
    e_addr[n] = a;
    e_data[n] = d;
    e_mrg[n] = 1'b0;
  endtask

  // One cycle: compare outputs with the model, advance the model, drop granted requests after the edge
  task automatic step();
    int s, n;
    bit ga, gl, gk;
    logic [31:0] ed;
    #1;
    s = cyc % 8;
    ga = 0; gl = 0; gk = 0;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        e_we[i] = 0; e_rd[i] = 0; e_busy[i] = 0; e_mrg[i] = 0;
      end
      closed_until = cyc;
    end else if (cyc >= closed_until) begin
      if (alu_valid && alu_wait >= STARVE) ga = 1;
      else if (link_valid) gk = 1;
      else if (ld_valid) gl = 1;
      else if (alu_valid) ga = 1;
    end
    ed = !e_mrg[s] ? e_data[s] :
         e_half[s] ? {mem[e_addr[s]][31:16], e_data[s][15:0]} : {mem[e_addr[s]][31:8], e_data[s][7:0]};
    checks++;
    if ({alu_ready, ld_ready, link_ready} !== {ga, gl, gk}) begin
      errors++;
      $display("FAIL ready cyc %0d: alu/ld/link got %b%b%b want %b%b%b", cyc, alu_ready, ld_ready, link_ready, ga, gl, gk);
    end
    checks++;
    if (rf_we !== e_we[s]) begin
      errors++;
      $display("FAIL rf_we cyc %0d: got %b want %b", cyc, rf_we, e_we[s]);
    end
    if (e_we[s]) begin
      checks++;
      if (rf_waddr !== e_addr[s] || rf_wdata !== ed) begin
        errors++;
        $display("FAIL write cyc %0d: got r%0d=%h want r%0d=%h", cyc, rf_waddr, rf_wdata, e_addr[s], ed);
      end
    end
    checks++;
    if (rf_rd_en !== e_rd[s]) begin
      errors++;
      $display("FAIL rf_rd_en cyc %0d: got %b want %b", cyc, rf_rd_en, e_rd[s]);
    end
    if (e_rd[s]) begin
      checks++;
      if (rf_rd_addr !== e_raddr[s]) begin
        errors++;
        $display("FAIL rf_rd_addr cyc %0d: got %0d want %0d", cyc, rf_rd_addr, e_raddr[s]);
      end
    end
    checks++;
    if (busy !== e_busy[s]) begin
      errors++;
      $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, e_busy[s]);
    end
    if (e_we[s]) mem[e_addr[s]] = ed;
    e_we[s] = 0; e_rd[s] = 0; e_busy[s] = 0; e_mrg[s] = 0;
    n = (cyc + 1) % 8;
    if (gk) sched(n, 5'd31, link_pc + 32'd4);
    if (ga) sched(n, alu_addr, alu_data);
    if (gl) begin
      if ((ld_size == 2'b01 || ld_size == 2'b10) && ld_addr != 5'd0) begin
        e_rd[n] = 1;
        e_raddr[n] = ld_addr;
        e_busy[n] = 1;
        e_busy[(cyc + 2) % 8] = 1;
        e_busy[(cyc + 3) % 8] = 1;
        e_we[(cyc + 3) % 8] = 1;
        e_addr[(cyc + 3) % 8] = ld_addr;
        e_data[(cyc + 3) % 8] = ld_data;
        e_mrg[(cyc + 3) % 8] = 1;
        e_half[(cyc + 3) % 8] = ld_size == 2'b01;
        closed_until = cyc + 3;
      end else
        sched(n, ld_addr, ld_data);
    end
    alu_wait = (reset_n && alu_valid && !ga) ? (alu_wait < STARVE ? alu_wait + 1 : STARVE) : 0;
    cyc++;
    @(posedge clk);
    #1;
    if (ga) alu_valid = 0;
    if (gl) ld_valid = 0;
    if (gk) link_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0;
    alu_valid = 1; alu_addr = 5'd3; alu_data = $urandom;
    ld_valid = 1; ld_addr = 5'd6; ld_data = $urandom; ld_size = 2'b00;
    link_valid = 1; link_pc = $urandom;
    repeat (3) step();
    reset_n = 1;
    repeat (4) step();
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    repeat (3) step();
  endtask

  task automatic test_simultaneous();
    link_valid = 1; link_pc = 32'h00400010;
    ld_valid = 1; ld_addr = 5'd8; ld_data = 32'h11111111; ld_size = 2'b11;
    alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h22222222;
    repeat (4) step();
    link_valid = 1; link_pc = 32'hFFFFFFFC;
    repeat (2) step();
  endtask

  task automatic test_byte_rmw();
    mem[4] = 32'h12345678;
    ld_valid = 1; ld_addr = 5'd4; ld_data = 32'h000000AB; ld_size = 2'b10;
    alu_valid = 1; alu_addr = 5'd12; alu_data = 32'hCAFEF00D;
    repeat (6) step();
    ld_valid = 1; ld_addr = 5'd4; ld_data = 32'hFFFF9876; ld_size = 2'b01;
    repeat (5) step();
  endtask

  task automatic test_starvation();
    alu_valid = 1; alu_addr = 5'd14; alu_data = $urandom;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1; ld_size = 2'b00; ld_addr = 5'($urandom_range(1, 31)); ld_data = $urandom;
      step();
    end
    ld_valid = 0;
    repeat (2) step();
  endtask

  task automatic test_r0_and_reset();
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
    repeat (2) step();
    ld_valid = 1; ld_addr = 5'd7; ld_data = $urandom; ld_size = 2'b01;
    repeat (2) step();
    ld_valid = 1;
    reset_n = 0;
    step();
    reset_n = 1;
    repeat (5) step();
    ld_valid = 1; ld_addr = 5'd0; ld_size = 2'b10;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n = $urandom_range(0, 99) != 0;
      if (!alu_valid && $urandom_range(0, 2) == 0) begin
        alu_valid = 1; alu_addr = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 2) == 0) begin
        ld_valid = 1; ld_addr = 5'($urandom_range(0, 31)); ld_data = $urandom; ld_size = 2'($urandom_range(0, 3));
      end
      if (!link_valid && $urandom_range(0, 4) == 0) begin
        link_valid = 1; link_pc = $urandom;
      end
      step();
    end
    reset_n = 1;
    alu_valid = 0; ld_valid = 0; link_valid = 0;
    repeat (4) step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      e_addr[i] = '0; e_raddr[i] = '0; e_data[i] = '0;
    end
    reset_n = 0;
    alu_valid = 0; ld_valid = 0; link_valid = 0;
    alu_addr = '0; alu_data = '0; ld_addr = '0; ld_data = '0; ld_size = '0; link_pc = '0;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_simultaneous();
    test_byte_rmw();
    test_starvation();
    test_r0_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
